mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single 16-bit system memory port (Addr/RD/WR/DataIn/DataOut) between two requesters.
//  Port 0 is the CVP14 core; port 1 is the host loader/debug port.
//  Round-robin arbitration with locked bursts, so VLD/VST 16-element transfers are never split.
//  Sits between the requesters and the memory; routes read data back to the port that issued the read.
// PARAMETERS
//  AW        16  address width
//  DW        16  data width
//  HOLD_MAX  16  max beats an unlocked owner keeps the bus while the other port requests
//  CNT_W     5   beat-counter width; must hold HOLD_MAX
// PORTS
//  Clk1      in   1   single clock, all state updates on posedge
//  Reset     in   1   synchronous, active-high reset
//  req0/1    in   1   port n requests bus ownership; level, held for the whole transfer
//  lock0/1   in   1   port n's current ownership is a locked burst (no preemption)
//  addr0/1   in   AW  port n address
//  rd0/1     in   1   port n read strobe (one beat)
//  wr0/1     in   1   port n write strobe (one beat)
//  wdata0/1  in   DW  port n write data
//  gnt0/1    out  1   port n owns the bus (registered)
//  rdata0/1  out  DW  read data to port n
//  rvalid0/1 out  1   rdata valid for port n (one-cycle pulse)
//  Addr      out  AW  memory address
//  RD        out  1   memory read
//  WR        out  1   memory write
//  DataOut   out  DW  memory write data
//  DataIn    in   DW  memory read data, valid the cycle after RD
// BEHAVIOUR
//  Reset values: gnt0/1=0, rvalid0/1=0, rdata0/1=0, RD=WR=0, Addr=0, DataOut=0, FSM=IDLE, beat count=0.
//  Reset mid-transfer: the next cycle is IDLE with no strobes. Any in-flight rvalid is dropped.
//  FSM states: IDLE, OWN0, OWN1.
//  IDLE, single request: go to the requester's OWN state. gnt rises the cycle after req (1-cycle grant latency).
//  IDLE, req0&req1: grant the port not served last (last_owner register, reset value 1, so port 0 wins first).
//  OWNn, reqn=0: release. The next state is evaluated as IDLE in the same cycle, so the other port may be granted the next cycle.
//  There is never a cycle with both gnt high.
//  OWNn, reqn=1, lockn=1: hold ownership. No preemption.
//  OWNn, reqn=1, lockn=0, other port requesting, beat count == HOLD_MAX-1: forced handover to the other port.
//  Beat counter: counts cycles with rd|wr from the owner.
//   Cleared on every grant change.
//   Saturates at HOLD_MAX-1.
//   Does not wrap.
//  Bus mux: combinational from the registered owner.
//   Addr=addr_owner, DataOut=wdata_owner, RD=rd_owner&gnt, WR=wr_owner&gnt.
//   When no owner: RD=WR=0, Addr and DataOut hold their last values.
//  rd&wr asserted together: WR wins; RD is suppressed; no rvalid.
//  Strobes from a non-owner port are ignored. No rvalid is generated for them.
//  Read return: a tag register captures the issuing port on each RD.
//   The next cycle, rdata_tag<=DataIn and rvalid_tag=1. The other port's rvalid=0.
//   Routing uses the tag, not the current grant, so a read on the last beat before handover still returns to its issuer.
//  Back-to-back reads: one read per cycle, each returned exactly one cycle later, in order.
// CONFIGURATION
//  ARB_STATS_EN defined:
//   Adds outputs stat_gnt0/1 (16-bit) counting grant rising edges per port, saturating at 16'hFFFF.
//   Adds stat_force (16-bit) counting forced handovers, saturating.
//   All reset to 0.
//  ARB_STATS_EN undefined: these ports and counters are absent. Arbitration behaviour is identical.
// STRUCTURE
//  Shared include cvp14_defs.vh holds:
//   FSM encodings ARB_IDLE=2'b00, ARB_OWN0=2'b01, ARB_OWN1=2'b10
//   default HOLD_MAX
//   port index constants PORT_CORE=0, PORT_HOST=1
//  One sub-module: arb_beat_cnt.
//   Saturating counter with clear/inc/at_limit.
//   Reused for the stats counters when ARB_STATS_EN is defined.
//  Top level contains: FSM, last_owner, read tag, bus mux.
// TESTING
//  1 Reset then req0=1, addr0=16'h0010, rd0=1 -> gnt0=1 next cycle; RD=1, Addr=16'h0010; rvalid0=1 the cycle after with rdata0=DataIn; rvalid1=0.
//  2 req0=req1=1 together out of reset -> gnt0 first. Drop req0 -> gnt1 the next cycle. Raise both again from IDLE -> gnt0 (port 1 was last served).
//  3 Port 0 locked 16-beat write burst (lock0=1) with req1=1 throughout -> 16 consecutive WR with Addr base..base+15; gnt1 stays 0 until req0 drops.
//  4 Port 0 unlocked streaming reads, HOLD_MAX=16, req1=1 -> forced handover after beat 16. The last port-0 read still gets rvalid0 after gnt1 rises. stat_force=1 when ARB_STATS_EN is defined.
//  5 rd1&wr1 both high while owning, wdata1=16'hBEEF -> WR=1, RD=0, DataOut=16'hBEEF, no rvalid1. wr0 from non-owner port 0 -> no strobe on the bus.
//  6 Assert Reset mid-burst after an RD -> next cycle gnt0/1=0, RD=WR=0, rvalid0/1=0; the next req0 is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM encodings, default hold limit,
// port indices and the idle-state grant selection.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_OWN0 = 2'b01,
    ARB_OWN1 = 2'b10
  } arb_state_e;

  localparam int   HOLD_MAX_DEFAULT = 16;
  localparam logic PORT_CORE        = 1'b0;
  localparam logic PORT_HOST        = 1'b1;

  // Grant choice from an idle bus; on a tie the port not served last wins.
  function automatic arb_state_e idle_pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return (last == PORT_CORE) ? ARB_OWN1 : ARB_OWN0;
    if (r0) return ARB_OWN0;
    if (r1) return ARB_OWN1;
    return ARB_IDLE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_beat_cnt.sv
// arb_beat_cnt: saturating up-counter with synchronous clear, used for the owner beat
// count and for the optional statistics counters.
module arb_beat_cnt #(
  parameter int           W     = 5,
  parameter logic [W-1:0] LIMIT = '1
) (
  input  logic         Clk1,
  input  logic         Reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         at_limit
);

  logic [W-1:0] count_reg;

  always_ff @(posedge Clk1) begin
    if (Reset || clear) begin
      count_reg <= '0;
    end else if (inc && !at_limit) begin
      count_reg <= count_reg + W'(1);
    end
  end

  assign count    = count_reg;
  assign at_limit = (count_reg == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between the core (port 0) and host (port 1).
// Define ARB_STATS_EN to add the stat_gnt0/stat_gnt1/stat_force counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int HOLD_MAX = HOLD_MAX_DEFAULT,
  parameter int CNT_W    = 5
) (
  input  logic          Clk1,
  input  logic          Reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic          rd0,
  input  logic          rd1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [AW-1:0] Addr,
  output logic          RD,
  output logic          WR,
  output logic [DW-1:0] DataOut,
  input  logic [DW-1:0] DataIn
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]   stat_gnt0,
  output logic [15:0]   stat_gnt1,
  output logic [15:0]   stat_force
`endif
);

  localparam logic [CNT_W-1:0] BEAT_LIMIT = CNT_W'(HOLD_MAX - 1);

  genvar gi;

  arb_state_e       state_reg, state_next;
  logic             last_owner_reg;
  logic             owner_valid, owner_sel;
  logic             force0, force1;
  logic             beat_inc, beat_clear, beat_at_limit;
  logic [CNT_W-1:0] beat_count_unused;
  logic [AW-1:0]    own_addr, addr_hold_reg;
  logic [DW-1:0]    own_wdata, dout_hold_reg;
  logic             own_rd, own_wr;
  logic             rd_pend_reg, rd_tag_reg;
  logic [1:0]       rvalid_vec;
  logic [DW-1:0]    rdata_vec [2];

  // Forced handover: unlocked owner has used its beats while the other port waits.
  assign force0 = req0 && !lock0 && req1 && beat_at_limit;
  assign force1 = req1 && !lock1 && req0 && beat_at_limit;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE: state_next = idle_pick(req0, req1, last_owner_reg);
      ARB_OWN0: begin
        if (!req0)       state_next = idle_pick(1'b0, req1, last_owner_reg);
        else if (force0) state_next = ARB_OWN1;
      end
      ARB_OWN1: begin
        if (!req1)       state_next = idle_pick(req0, 1'b0, last_owner_reg);
        else if (force1) state_next = ARB_OWN0;
      end
      default: state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      state_reg      <= ARB_IDLE;
      last_owner_reg <= PORT_HOST;
    end else begin
      state_reg <= state_next;
      if (owner_valid) last_owner_reg <= owner_sel;
    end
  end

  assign beat_inc   = owner_valid && (own_rd || own_wr);
  assign beat_clear = (state_next != state_reg);

  arb_beat_cnt #(.W(CNT_W), .LIMIT(BEAT_LIMIT)) u_beat_cnt (
    .Clk1     (Clk1),
    .Reset    (Reset),
    .clear    (beat_clear),
    .inc      (beat_inc),
    .count    (beat_count_unused),
    .at_limit (beat_at_limit)
  );

  // Bus mux driven from the registered owner; address/data park on the last owner's values.
  assign owner_valid = (state_reg != ARB_IDLE);
  assign owner_sel   = (state_reg == ARB_OWN1);
  assign gnt0        = (state_reg == ARB_OWN0);
  assign gnt1        = (state_reg == ARB_OWN1);
  assign own_addr    = owner_sel ? addr1  : addr0;
  assign own_wdata   = owner_sel ? wdata1 : wdata0;
  assign own_rd      = owner_sel ? rd1    : rd0;
  assign own_wr      = owner_sel ? wr1    : wr0;

  assign WR      = owner_valid && own_wr;
  assign RD      = owner_valid && own_rd && !own_wr;
  assign Addr    = owner_valid ? own_addr  : addr_hold_reg;
  assign DataOut = owner_valid ? own_wdata : dout_hold_reg;

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      addr_hold_reg <= '0;
      dout_hold_reg <= '0;
      rd_pend_reg   <= 1'b0;
      rd_tag_reg    <= PORT_CORE;
    end else begin
      if (owner_valid) begin
        addr_hold_reg <= own_addr;
        dout_hold_reg <= own_wdata;
      end
      rd_pend_reg <= RD;
      if (RD) rd_tag_reg <= owner_sel;
    end
  end

  // Read data returns to the tagged issuer, independent of who owns the bus now.
  for (gi = 0; gi < 2; gi++) begin : g_rport
    logic [DW-1:0] hold_reg;
    assign rvalid_vec[gi] = rd_pend_reg && (rd_tag_reg == 1'(gi));
    always_ff @(posedge Clk1) begin
      if (Reset)               hold_reg <= '0;
      else if (rvalid_vec[gi]) hold_reg <= DataIn;
    end
    assign rdata_vec[gi] = rvalid_vec[gi] ? DataIn : hold_reg;
  end

  assign rvalid0 = rvalid_vec[0];
  assign rvalid1 = rvalid_vec[1];
  assign rdata0  = rdata_vec[0];
  assign rdata1  = rdata_vec[1];

`ifdef ARB_STATS_EN
  logic [2:0]  stat_inc;
  logic [2:0]  stat_sat_unused;
  logic [15:0] stat_cnt [3];

  assign stat_inc[0] = (state_next == ARB_OWN0) && (state_reg != ARB_OWN0);
  assign stat_inc[1] = (state_next == ARB_OWN1) && (state_reg != ARB_OWN1);
  assign stat_inc[2] = ((state_reg == ARB_OWN0) && force0) || ((state_reg == ARB_OWN1) && force1);

  for (gi = 0; gi < 3; gi++) begin : g_stat
    arb_beat_cnt #(.W(16), .LIMIT(16'hFFFF)) u_stat_cnt (
      .Clk1     (Clk1),
      .Reset    (Reset),
      .clear    (1'b0),
      .inc      (stat_inc[gi]),
      .count    (stat_cnt[gi]),
      .at_limit (stat_sat_unused[gi])
    );
  end

  assign stat_gnt0  = stat_cnt[0];
  assign stat_gnt1  = stat_cnt[1];
  assign stat_force = stat_cnt[2];
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized traffic against an
// owner/queue-level reference model and a simple registered-read memory.
module tb_mem_port_arbiter;

  localparam int HOLD = 16;

  logic        Clk1 = 1'b0;
  logic        Reset;
  logic        req0, req1, lock0, lock1, rd0, rd1, wr0, wr1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, RD, WR;
  logic [15:0] rdata0, rdata1, Addr, DataOut, DataIn;
`ifdef ARB_STATS_EN
  logic [15:0] stat_gnt0, stat_gnt1, stat_force;
`endif

  always #5 Clk1 = ~Clk1;

  mem_port_arbiter dut (
    .Clk1(Clk1), .Reset(Reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1), .rd0(rd0), .rd1(rd1), .wr0(wr0), .wr1(wr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rdata0(rdata0), .rdata1(rdata1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .Addr(Addr), .RD(RD), .WR(WR), .DataOut(DataOut), .DataIn(DataIn)
`ifdef ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_force(stat_force)
`endif
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  // Memory: write on WR, read data available the cycle after the address.
  logic [15:0] mem [256];
  logic        mem_ready = 1'b0;
  always @(posedge Clk1) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (WR) begin
      mem[Addr[7:0]] <= DataOut;
    end
    DataIn <= mem[Addr[7:0]];
  end

  // Reference model state
  int          m_owner, m_last, m_beats, m_rv_port;
  bit          m_rv_pend;
  logic [15:0] m_addr_hold, m_dout_hold, m_rv_data, m_rd_hold0, m_rd_hold1;
  logic [15:0] ref_mem [256];
`ifdef ARB_STATS_EN
  int          m_force;
`endif
  logic        e_gnt0, e_gnt1, e_RD, e_WR, e_rv0, e_rv1;
  logic [15:0] e_Addr, e_DataOut, e_rd0, e_rd1;
  logic [71:0] exp_bus, obs_bus;
  int          vectors, miscompares;

  assign obs_bus = {gnt0, gnt1, RD, WR, rvalid0, rvalid1, 2'b00, Addr, DataOut, rdata0, rdata1};

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_beats = 0; m_rv_pend = 0; m_rv_port = 0;
    m_addr_hold = '0; m_dout_hold = '0; m_rv_data = '0; m_rd_hold0 = '0; m_rd_hold1 = '0;
`ifdef ARB_STATS_EN
    m_force = 0;
`endif
  endtask

  task automatic model_eval();
    logic o_rd, o_wr;
    o_rd = (m_owner == 1) ? rd1 : rd0;
    o_wr = (m_owner == 1) ? wr1 : wr0;
    e_gnt0 = (m_owner == 0);
    e_gnt1 = (m_owner == 1);
    if (m_owner >= 0) begin
      e_WR = o_wr; e_RD = o_rd && !o_wr;
      e_Addr = (m_owner == 1) ? addr1 : addr0;
      e_DataOut = (m_owner == 1) ? wdata1 : wdata0;
    end else begin
      e_WR = 0; e_RD = 0; e_Addr = m_addr_hold; e_DataOut = m_dout_hold;
    end
    e_rv0 = m_rv_pend && (m_rv_port == 0);
    e_rv1 = m_rv_pend && (m_rv_port == 1);
    e_rd0 = e_rv0 ? m_rv_data : m_rd_hold0;
    e_rd1 = e_rv1 ? m_rv_data : m_rd_hold1;
    exp_bus = {e_gnt0, e_gnt1, e_RD, e_WR, e_rv0, e_rv1, 2'b00, e_Addr, e_DataOut, e_rd0, e_rd1};
  endtask

  task automatic model_update();
    int nxt;
    bit r [2];
    bit lk [2];
    if (e_rv0) m_rd_hold0 = m_rv_data;
    if (e_rv1) m_rd_hold1 = m_rv_data;
    m_rv_pend = e_RD;
    if (e_RD) begin m_rv_port = m_owner; m_rv_data = ref_mem[e_Addr[7:0]]; end
    if (e_WR) ref_mem[e_Addr[7:0]] = e_DataOut;
    if (m_owner >= 0) begin m_addr_hold = e_Addr; m_dout_hold = e_DataOut; m_last = m_owner; end
    r[0] = req0; r[1] = req1; lk[0] = lock0; lk[1] = lock1;
    nxt = m_owner;
    if (m_owner >= 0 && r[m_owner]) begin
      if (!lk[m_owner] && r[1-m_owner] && m_beats >= HOLD - 1) begin
        nxt = 1 - m_owner;
`ifdef ARB_STATS_EN
        m_force++;
`endif
      end
    end else if (r[0] && r[1]) nxt = 1 - m_last;
    else if (r[0]) nxt = 0;
    else if (r[1]) nxt = 1;
    else nxt = -1;
    if (nxt != m_owner) m_beats = 0;
    else if (m_owner >= 0 && (e_RD || e_WR)) m_beats++;
    m_owner = nxt;
    if (Reset) model_reset();
  endtask

  task automatic tick();
    model_update();
    @(posedge Clk1);
    #1;
  endtask

  task automatic settle();
    #2;
    model_eval();
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0; rd0 = 0; rd1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    Reset = 1; settle(); tick(); settle(); tick();
    Reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Reset = 1; settle(); tick();
    settle();
    vectors++;
    if (obs_bus !== 72'h0) begin
      miscompares++; $display("FAIL reset_state got %h want 0", obs_bus);
    end
    tick(); Reset = 0;
  endtask

  task automatic test_single_read();
    do_reset();
    req0 = 1; addr0 = 16'h0010; rd0 = 1; settle();
    vectors++;
    if (gnt0 !== 1'b0 || RD !== 1'b0) begin
      miscompares++; $display("FAIL rd_latency got gnt0=%b RD=%b want 0 0", gnt0, RD);
    end
    tick(); settle();
    vectors++;
    if ({gnt0, RD, Addr} !== {1'b1, 1'b1, 16'h0010}) begin
      miscompares++; $display("FAIL rd_issue got gnt0=%b RD=%b Addr=%h want 1 1 0010", gnt0, RD, Addr);
    end
    tick(); rd0 = 0; settle();
    vectors++;
    if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata0 !== init_val(16)) begin
      miscompares++; $display("FAIL rd_return got rv0=%b rv1=%b rdata0=%h want 1 0 %h", rvalid0, rvalid1, rdata0, init_val(16));
    end
    tick();
  endtask

  task automatic test_arbitration();
    do_reset();
    req0 = 1; req1 = 1; settle(); tick();
    settle();
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL arb_first got %b want 10", {gnt0, gnt1}); end
    tick();
    req0 = 0; settle();
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL arb_release got %b want 10", {gnt0, gnt1}); end
    tick(); settle();
    vectors++;
    if ({gnt0, gnt1} !== 2'b01) begin miscompares++; $display("FAIL arb_switch got %b want 01", {gnt0, gnt1}); end
    tick();
    req1 = 0; settle(); tick();
    settle();
    vectors++;
    if ({gnt0, gnt1} !== 2'b00) begin miscompares++; $display("FAIL arb_idle got %b want 00", {gnt0, gnt1}); end
    tick();
    req0 = 1; req1 = 1; settle(); tick();
    settle();
    vectors++;
    if ({gnt0, gnt1} !== 2'b10) begin miscompares++; $display("FAIL arb_rr got %b want 10", {gnt0, gnt1}); end
    tick();
  endtask

  task automatic test_locked_burst();
    logic [15:0] wd [16];
    do_reset();
    req0 = 1; lock0 = 1; req1 = 1; settle(); tick();
    for (int i = 0; i < 16; i++) begin
      wr0 = 1; addr0 = 16'h0080 + 16'(i); wd[i] = 16'($urandom); wdata0 = wd[i];
      settle();
      vectors++;
      if ({WR, gnt1, Addr, DataOut} !== {1'b1, 1'b0, 16'h0080 + 16'(i), wd[i]}) begin
        miscompares++;
        $display("FAIL burst_beat%0d got WR=%b gnt1=%b Addr=%h Dout=%h want 1 0 %h %h", i, WR, gnt1, Addr, DataOut, 16'h0080 + 16'(i), wd[i]);
      end
      tick();
    end
    wr0 = 0; settle();
    vectors++;
    if (gnt1 !== 1'b0) begin miscompares++; $display("FAIL burst_hold got gnt1=%b want 0", gnt1); end
    tick();
    req0 = 0; lock0 = 0; settle(); tick();
    settle();
    vectors++;
    if ({gnt0, gnt1} !== 2'b01) begin miscompares++; $display("FAIL burst_handover got %b want 01", {gnt0, gnt1}); end
    tick();
    for (int i = 0; i <= 16; i++) begin
      rd1 = (i < 16); addr1 = 16'h0080 + 16'(i % 16);
      settle();
      if (i > 0) begin
        vectors++;
        if (rvalid1 !== 1'b1 || rdata1 !== wd[i-1]) begin
          miscompares++; $display("FAIL burst_readback%0d got rv1=%b data=%h want 1 %h", i - 1, rvalid1, rdata1, wd[i-1]);
        end
      end
      tick();
    end
    rd1 = 0;
  endtask

  task automatic test_forced_handover();
    int beats;
    bit done;
    beats = 0; done = 0;
    do_reset();
    req0 = 1; req1 = 1; rd0 = 1;
    for (int c = 0; c < 40 && !done; c++) begin
      addr0 = 16'h0040 + 16'(beats);
      settle();
      vectors++;
      if (obs_bus !== exp_bus) begin miscompares++; $display("FAIL force_cycle%0d got %h want %h", c, obs_bus, exp_bus); end
      if (gnt1) begin
        done = 1;
        vectors++;
        if (beats != HOLD || rvalid0 !== 1'b1 || rdata0 !== init_val(16'h004F)) begin
          miscompares++; $display("FAIL force_last got beats=%0d rv0=%b rdata0=%h want %0d 1 %h", beats, rvalid0, rdata0, HOLD, init_val(16'h004F));
        end
`ifdef ARB_STATS_EN
        vectors++;
        if (stat_force !== 16'd1) begin miscompares++; $display("FAIL stat_force got %0d want 1", stat_force); end
`endif
      end else if (gnt0 && RD) beats++;
      tick();
    end
    if (!done) begin
      vectors++; miscompares++; $display("FAIL force_timeout got no gnt1 want gnt1 after %0d beats", HOLD);
    end
    idle_inputs();
  endtask

  task automatic test_strobe_rules();
    do_reset();
    req1 = 1; settle(); tick();
    rd1 = 1; wr1 = 1; wdata1 = 16'hBEEF; addr1 = 16'h0020;
    req0 = 1; wr0 = 1; addr0 = 16'h0030; wdata0 = 16'h1234;
    settle();
    vectors++;
    if ({WR, RD, DataOut, Addr} !== {1'b1, 1'b0, 16'hBEEF, 16'h0020}) begin
      miscompares++; $display("FAIL rdwr_both got WR=%b RD=%b Dout=%h Addr=%h want 1 0 beef 0020", WR, RD, DataOut, Addr);
    end
    tick();
    rd1 = 0; wr1 = 0; settle();
    vectors++;
    if ({rvalid1, WR, RD} !== 3'b000) begin
      miscompares++; $display("FAIL nonowner_ignored got rv1=%b WR=%b RD=%b want 0 0 0", rvalid1, WR, RD);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req0 = 1; rd0 = 1; addr0 = 16'h0050; settle(); tick();
    settle();
    vectors++;
    if (RD !== 1'b1) begin miscompares++; $display("FAIL midrst_rd got RD=%b want 1", RD); end
    Reset = 1; tick();
    Reset = 0; rd0 = 0; settle();
    vectors++;
    if ({gnt0, gnt1, RD, WR, rvalid0, rvalid1} !== 6'b0) begin
      miscompares++; $display("FAIL midrst_state got %b want 000000", {gnt0, gnt1, RD, WR, rvalid0, rvalid1});
    end
    tick(); settle();
    vectors++;
    if (gnt0 !== 1'b1) begin miscompares++; $display("FAIL midrst_regrant got gnt0=%b want 1", gnt0); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) req0 = ~req0;
      if ($urandom_range(0, 7) == 0) req1 = ~req1;
      lock0 = ($urandom_range(0, 3) == 0);
      lock1 = ($urandom_range(0, 3) == 0);
      rd0 = 1'($urandom_range(0, 1)); rd1 = 1'($urandom_range(0, 1));
      wr0 = ($urandom_range(0, 3) == 0); wr1 = ($urandom_range(0, 3) == 0);
      addr0 = {8'h00, 8'($urandom)}; addr1 = {8'h00, 8'($urandom)};
      wdata0 = 16'($urandom); wdata1 = 16'($urandom);
      Reset = ($urandom_range(0, 199) == 0);
      settle();
      vectors++;
      if (obs_bus !== exp_bus) begin miscompares++; $display("FAIL random_cycle%0d got %h want %h", c, obs_bus, exp_bus); end
      tick();
    end
    Reset = 0;
    idle_inputs();
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    Reset = 1; idle_inputs(); model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    @(posedge Clk1); #1;
    test_reset();
    test_single_read();
    test_arbitration();
    test_locked_burst();
    test_forced_handover();
    test_strobe_rules();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
